fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: walks a PC through a negedge-registered program ROM and
// presents one instruction per cycle over a valid/ready handshake, with redirect and halt.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  jump_en,
  input  logic [ADDR_WIDTH-1:0] jump_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  halted,
  output logic [15:0]           fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_ONE    = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [15:0]           COUNT_MAX = 16'hFFFF;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                    valid_q, valid_d;
  logic                    halted_q, halted_d;
  logic [15:0]             count_q, count_d;
  logic                    handshake_s;
  logic                    load_s;

  // Next-state logic: handshake retire first, then redirect or capture.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    ipc_d       = ipc_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    count_d     = count_q;
    handshake_s = valid_q & instr_ready;
    load_s      = ~valid_q | instr_ready;

    // A retiring handshake is counted even when a redirect lands in the same cycle.
    if (handshake_s) begin
      valid_d = 1'b0;
      if (count_q != COUNT_MAX) begin
        count_d = count_q + 16'd1;
      end else begin
        count_d = COUNT_MAX;
      end
    end else begin
      count_d = count_q;
    end

    if (jump_en) begin
      pc_d     = jump_addr;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      state_d  = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (load_s) begin
            instr_d = rom_data;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            // The halt word is delivered but the PC parks on its address.
            if (rom_data == HALT_WORD) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_q + PC_ONE;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_HALT: begin
          state_d = ST_HALT;
        end
        default: begin
          state_d = ST_BOOT;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= 16'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  assign rom_addr    = pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, word) pairs are queued as stimulus is
// applied and retired against the DUT whenever a handshake is observed.
module tb_fetch_unit;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [7:0]  instr_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] rom [256];
  exp_t        exp_q[$];
  exp_t        e;
  int          n_checks = 0;
  int          n_fail   = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) rom_data <= rom[rom_addr];

  task automatic init_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
  endtask

  task automatic do_reset(input logic rdy);
    @(negedge clk);
    rst_n       = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    instr_ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0000 || instr_pc !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: valid/out/pc=%b/%h/%h required 0/0000/00", instr_valid, instr_out, instr_pc);
    end
    n_checks++;
    if (rom_addr !== 8'h00 || halted !== 1'b0 || fetch_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: addr/halted/count=%h/%b/%h required 00/0/0000", rom_addr, halted, fetch_count);
    end
  endtask

  task automatic test_stream();
    #1;
    rom[0] = 16'd1; rom[1] = 16'd2; rom[2] = 16'd3; rom[3] = 16'd4;
    do_reset(1'b1);
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL boot_cycle: valid/addr=%b/%h required 0/00", instr_valid, rom_addr);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back('{pc: 8'(i), data: 16'(i + 1)});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (instr_pc !== e.pc || instr_out !== e.data) begin
          n_fail++;
          $display("FAIL stream_word: pc/instr=%h/%h required %h/%h", instr_pc, instr_out, e.pc, e.data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_timeout: %0d words outstanding, 0 required", exp_q.size());
      exp_q.delete();
    end
    n_checks++;
    if (fetch_count !== 16'd4) begin
      n_fail++;
      $display("FAIL stream_count: count=%0d required 4", fetch_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset(1'b0);
    @(negedge clk);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      n_checks++;
      if (instr_valid !== 1'b1 || instr_out !== 16'd1 || instr_pc !== 8'h00 || rom_addr !== 8'h01) begin
        n_fail++;
        $display("FAIL stall_hold: valid/out/pc/addr=%b/%h/%h/%h required 1/0001/00/01", instr_valid, instr_out, instr_pc, rom_addr);
      end
    end
    instr_ready = 1'b1;
    exp_q.push_back('{pc: 8'h00, data: 16'd1});
    exp_q.push_back('{pc: 8'h01, data: 16'd2});
    exp_q.push_back('{pc: 8'h02, data: 16'd3});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (instr_pc !== e.pc || instr_out !== e.data) begin
          n_fail++;
          $display("FAIL stall_release: pc/instr=%h/%h required %h/%h", instr_pc, instr_out, e.pc, e.data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0 || fetch_count !== 16'd3) begin
      n_fail++;
      $display("FAIL stall_count: outstanding=%0d count=%0d required 0 and 3", exp_q.size(), fetch_count);
      exp_q.delete();
    end
  endtask

  task automatic test_jump();
    do_reset(1'b1);
    repeat (7) @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h05) begin
      n_fail++;
      $display("FAIL jump_setup: valid/pc=%b/%h required 1/05", instr_valid, instr_pc);
    end
    instr_ready = 1'b0;
    jump_en     = 1'b1;
    jump_addr   = 8'h40;
    @(negedge clk);
    n_checks++;
    if (instr_valid !== 1'b0 || rom_addr !== 8'h40 || fetch_count !== 16'd5) begin
      n_fail++;
      $display("FAIL jump_squash: valid/addr/count=%b/%h/%0d required 0/40/5", instr_valid, rom_addr, fetch_count);
    end
    jump_en     = 1'b0;
    instr_ready = 1'b1;
    exp_q.push_back('{pc: 8'h40, data: rom[8'h40]});
    exp_q.push_back('{pc: 8'h41, data: rom[8'h41]});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (instr_pc !== e.pc || instr_out !== e.data) begin
          n_fail++;
          $display("FAIL jump_target: pc/instr=%h/%h required %h/%h", instr_pc, instr_out, e.pc, e.data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL jump_timeout: %0d words outstanding, 0 required", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_halt();
    #1;
    rom[2] = 16'hFFFF;
    do_reset(1'b1);
    exp_q.push_back('{pc: 8'h00, data: rom[0]});
    exp_q.push_back('{pc: 8'h01, data: rom[1]});
    exp_q.push_back('{pc: 8'h02, data: 16'hFFFF});
    @(negedge clk);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (instr_pc !== e.pc || instr_out !== e.data) begin
          n_fail++;
          $display("FAIL halt_word: pc/instr=%h/%h required %h/%h", instr_pc, instr_out, e.pc, e.data);
        end
      end
      @(negedge clk);
    end
    for (int h = 0; h < 2; h++) begin
      n_checks++;
      if (exp_q.size() != 0 || halted !== 1'b1 || instr_valid !== 1'b0 || rom_addr !== 8'h02 || fetch_count !== 16'd3) begin
        n_fail++;
        $display("FAIL halt_state: outstanding=%0d halted/valid/addr/count=%b/%b/%h/%0d required 0 1/0/02/3",
                 exp_q.size(), halted, instr_valid, rom_addr, fetch_count);
        exp_q.delete();
      end
      @(negedge clk);
    end
    jump_en   = 1'b1;
    jump_addr = 8'h00;
    @(negedge clk);
    n_checks++;
    if (halted !== 1'b0 || rom_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL halt_exit: halted/addr=%b/%h required 0/00", halted, rom_addr);
    end
    jump_en = 1'b0;
    exp_q.push_back('{pc: 8'h00, data: rom[0]});
    exp_q.push_back('{pc: 8'h01, data: rom[1]});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (instr_pc !== e.pc || instr_out !== e.data) begin
          n_fail++;
          $display("FAIL halt_restart: pc/instr=%h/%h required %h/%h", instr_pc, instr_out, e.pc, e.data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL halt_timeout: %0d words outstanding, 0 required", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    #1;
    init_rom();
    do_reset(1'b1);
    @(negedge clk);
    jump_en   = 1'b1;
    jump_addr = 8'hFE;
    @(negedge clk);
    jump_en = 1'b0;
    exp_q.push_back('{pc: 8'hFE, data: rom[8'hFE]});
    exp_q.push_back('{pc: 8'hFF, data: rom[8'hFF]});
    exp_q.push_back('{pc: 8'h00, data: rom[8'h00]});
    exp_q.push_back('{pc: 8'h01, data: rom[8'h01]});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        e = exp_q.pop_front();
        n_checks++;
        if (instr_pc !== e.pc || instr_out !== e.data) begin
          n_fail++;
          $display("FAIL wrap_word: pc/instr=%h/%h required %h/%h", instr_pc, instr_out, e.pc, e.data);
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (exp_q.size() != 0 || fetch_count !== 16'd4) begin
      n_fail++;
      $display("FAIL wrap_count: outstanding=%0d count=%0d required 0 and 4", exp_q.size(), fetch_count);
      exp_q.delete();
    end
    jump_en   = 1'b1;
    jump_addr = 8'h10;
    @(negedge clk);
    jump_en = 1'b0;
    n_checks++;
    if (fetch_count !== 16'd5 || instr_valid !== 1'b0 || rom_addr !== 8'h10) begin
      n_fail++;
      $display("FAIL jump_handshake: count/valid/addr=%0d/%b/%h required 5/0/10", fetch_count, instr_valid, rom_addr);
    end
  endtask

  task automatic test_saturate_and_async_reset();
    logic reached;
    do_reset(1'b1);
    reached = 1'b0;
    for (int c = 0; c < 70000 && !reached; c++) begin
      @(negedge clk);
      if (fetch_count == 16'hFFFF) reached = 1'b1;
    end
    n_checks++;
    if (!reached) begin
      n_fail++;
      $display("FAIL sat_timeout: count=%h, required FFFF within budget", fetch_count);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (fetch_count !== 16'hFFFF || instr_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: count/valid=%h/%b required FFFF/1", fetch_count, instr_valid);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0000 || instr_pc !== 8'h00 ||
        rom_addr !== 8'h00 || halted !== 1'b0 || fetch_count !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: valid/out/pc/addr/halted/count=%b/%h/%h/%h/%b/%h required all zero",
               instr_valid, instr_out, instr_pc, rom_addr, halted, fetch_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 8'h00;
    instr_ready = 1'b0;
    init_rom();
    test_reset();
    test_stream();
    test_backpressure();
    test_jump();
    test_halt();
    test_wrap();
    test_saturate_and_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
